// File: rtl/dwt_block_loader.sv
// ---------------------------------------------------------------------------
// dwt_block_loader
//   Raster-to-block converter feeding the DWT stage. Raster words (8 pixels
//   per word, leftmost pixel in the top byte) are written into a ping-pong
//   store of two banks, each holding 8 image lines. Once a bank holds a
//   complete 8-line band, it is read out one 8x8 block per cycle. Each block
//   is presented as eight row words.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous reset, active-high
//   pix_valid    raster word valid
//   pix_ready    loader can accept a raster word (transfer = valid & ready)
//   pix_data     raster word, line-major, left to right
//   blk_valid    blk_row1..8 hold a valid block
//   blk_ready    consumer takes the block (transfer = valid & ready)
//   blk_row1..8  block rows 0..7 (row r = word from band line r)
//   blk_last     marks the final block of the frame
// ---------------------------------------------------------------------------
module dwt_block_loader #(
  parameter int DATA_W  = 64,
  parameter int W_WORDS = 32,
  parameter int H_BANDS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [DATA_W-1:0] blk_row1,
  output logic [DATA_W-1:0] blk_row2,
  output logic [DATA_W-1:0] blk_row3,
  output logic [DATA_W-1:0] blk_row4,
  output logic [DATA_W-1:0] blk_row5,
  output logic [DATA_W-1:0] blk_row6,
  output logic [DATA_W-1:0] blk_row7,
  output logic [DATA_W-1:0] blk_row8,
  output logic              blk_last
);

  localparam int CW    = (W_WORDS > 1) ? $clog2(W_WORDS) : 1;
  localparam int BW    = (H_BANDS > 1) ? $clog2(H_BANDS) : 1;
  // Each line memory holds both banks: address = {bank, column}.
  localparam int DEPTH = 2 * (2 ** CW);
  localparam logic [CW-1:0] COL_LAST  = CW'(W_WORDS - 1);
  localparam logic [BW-1:0] BAND_LAST = BW'(H_BANDS - 1);

  logic [CW-1:0] wcol_q, wcol_d;
  logic [2:0]    wline_q, wline_d;
  logic          wbank_q, wbank_d;
  logic [CW-1:0] rcol_q, rcol_d;
  logic          rbank_q, rbank_d;
  logic [BW-1:0] band_q, band_d;
  logic [1:0]    full_q, full_d;
  logic          blk_valid_q, blk_valid_d;
  logic          blk_last_q, blk_last_d;

  logic accept;
  logic load;
  logic [7:0][DATA_W-1:0] row_bus;

  // Ready depends only on registered state, never on blk_ready.
  assign pix_ready = ~full_q[wbank_q];
  assign accept    = pix_valid & pix_ready;
  // A new block is fetched when the read bank is complete and the output
  // register is empty or being emptied this cycle.
  assign load      = full_q[rbank_q] & (~blk_valid_q | blk_ready);

  // One line memory per band line; the block row register doubles as the
  // registered read port of that memory.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] row_q;

      always_ff @(posedge clk) begin
        if (accept && (wline_q == 3'(gi))) begin
          mem[{wbank_q, wcol_q}] <= pix_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          row_q <= '0;
        end else if (load) begin
          row_q <= mem[{rbank_q, rcol_q}];
        end
      end

      assign row_bus[gi] = row_q;
    end
  endgenerate

  assign blk_row1  = row_bus[0];
  assign blk_row2  = row_bus[1];
  assign blk_row3  = row_bus[2];
  assign blk_row4  = row_bus[3];
  assign blk_row5  = row_bus[4];
  assign blk_row6  = row_bus[5];
  assign blk_row7  = row_bus[6];
  assign blk_row8  = row_bus[7];
  assign blk_valid = blk_valid_q;
  assign blk_last  = blk_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcol_q      <= '0;
      wline_q     <= '0;
      wbank_q     <= 1'b0;
      rcol_q      <= '0;
      rbank_q     <= 1'b0;
      band_q      <= '0;
      full_q      <= '0;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      wcol_q      <= wcol_d;
      wline_q     <= wline_d;
      wbank_q     <= wbank_d;
      rcol_q      <= rcol_d;
      rbank_q     <= rbank_d;
      band_q      <= band_d;
      full_q      <= full_d;
      blk_valid_q <= blk_valid_d;
      blk_last_q  <= blk_last_d;
    end
  end

  always_comb begin
    wcol_d      = wcol_q;
    wline_d     = wline_q;
    wbank_d     = wbank_q;
    rcol_d      = rcol_q;
    rbank_d     = rbank_q;
    band_d      = band_q;
    full_d      = full_q;
    blk_valid_d = blk_valid_q;
    blk_last_d  = blk_last_q;

    // Write side: fill the current bank line by line.
    if (accept) begin
      if (wcol_q == COL_LAST) begin
        wcol_d = '0;
        if (wline_q == 3'd7) begin
          wline_d         = '0;
          wbank_d         = ~wbank_q;
          full_d[wbank_q] = 1'b1;
        end else begin
          wline_d = wline_q + 3'd1;
        end
      end else begin
        wcol_d = wcol_q + CW'(1);
      end
    end

    // Read side. The writer only ever targets a non-full bank and the reader
    // only a full one, so the set above and the clear below never hit the
    // same flag in one cycle.
    if (load) begin
      blk_valid_d = 1'b1;
      blk_last_d  = (rcol_q == COL_LAST) && (band_q == BAND_LAST);
      if (rcol_q == COL_LAST) begin
        rcol_d          = '0;
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
        band_d          = (band_q == BAND_LAST) ? '0 : band_q + BW'(1);
      end else begin
        rcol_d = rcol_q + CW'(1);
      end
    end else if (blk_ready) begin
      // Block consumed and nothing ready behind it.
      blk_valid_d = 1'b0;
      blk_last_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_dwt_block_loader.sv
// ---------------------------------------------------------------------------
// tb_dwt_block_loader
//   Directed self-checking bench for dwt_block_loader (256x256 frame,
//   32 words per line, 32 bands). Raster words carry their frame line and
//   column in the low bytes plus a per-test tag in the top bits, so each
//   expected block row is known directly from (band, column, row).
// ---------------------------------------------------------------------------
module tb_dwt_block_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic        pix_ready;
  logic [63:0] pix_data;
  logic        blk_valid;
  logic        blk_ready;
  logic [63:0] blk_row1, blk_row2, blk_row3, blk_row4;
  logic [63:0] blk_row5, blk_row6, blk_row7, blk_row8;
  logic        blk_last;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Values seen just before the most recent edge, plus the transfers that
  // took place at that edge.
  logic            s_prdy, s_bval, s_last;
  logic [7:0][63:0] s_rows;
  logic            p_acc, b_acc;

  always #5 clk = ~clk;

  dwt_block_loader #(
    .DATA_W (64),
    .W_WORDS(32),
    .H_BANDS(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data (pix_data),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .blk_row1 (blk_row1),
    .blk_row2 (blk_row2),
    .blk_row3 (blk_row3),
    .blk_row4 (blk_row4),
    .blk_row5 (blk_row5),
    .blk_row6 (blk_row6),
    .blk_row7 (blk_row7),
    .blk_row8 (blk_row8),
    .blk_last (blk_last)
  );

  // Raster word for frame line / column, tagged in the top 16 bits.
  function automatic logic [63:0] pix(input logic [15:0] tag, input int line, input int col);
    return {tag, 32'h0, 8'(line), 8'(col)};
  endfunction

  // Drive inputs for one cycle, sample outputs, advance one edge.
  task automatic step(input logic pv, input logic [63:0] pd, input logic br);
    rst       = 1'b0;
    pix_valid = pv;
    pix_data  = pd;
    blk_ready = br;
    s_prdy    = pix_ready;
    s_bval    = blk_valid;
    s_last    = blk_last;
    s_rows    = {blk_row8, blk_row7, blk_row6, blk_row5,
                 blk_row4, blk_row3, blk_row2, blk_row1};
    p_acc     = pv & s_prdy;
    b_acc     = s_bval & br;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    blk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0][63:0] rows;
    do_reset();
    rows = {blk_row8, blk_row7, blk_row6, blk_row5,
            blk_row4, blk_row3, blk_row2, blk_row1};
    checks++;
    if (blk_valid !== 1'b0) begin
      errors++; $display("FAIL reset_blk_valid: got %b expected 0", blk_valid);
    end
    checks++;
    if (blk_last !== 1'b0) begin
      errors++; $display("FAIL reset_blk_last: got %b expected 0", blk_last);
    end
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++; $display("FAIL reset_pix_ready: got %b expected 1", pix_ready);
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (rows[r] !== 64'h0) begin
        errors++; $display("FAIL reset_row%0d: got %h expected 0", r + 1, rows[r]);
      end
    end
    $display("test_reset: done");
  endtask

  // One band, consumer always ready: 32 blocks, row r of block c = {r, c}.
  task automatic test_one_band();
    int w = 0, k = 0, acc_edge = -1, first_val = -1;
    bit rdy_ok = 1'b1;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(w < 256, pix(16'h0, w / 32, w % 32), 1'b1);
      if (s_bval && first_val < 0) first_val = cyc - 1;
      if (!s_prdy) rdy_ok = 1'b0;
      if (p_acc && w == 255) acc_edge = cyc;
      if (p_acc) w++;
      if (b_acc) begin
        for (int r = 0; r < 8; r++) begin
          checks++;
          if (s_rows[r] !== {48'h0, 8'(r), 8'(k)}) begin
            errors++;
            $display("FAIL band_row blk%0d row%0d: got %h expected %h",
                     k, r, s_rows[r], {48'h0, 8'(r), 8'(k)});
          end
        end
        checks++;
        if (s_last !== 1'b0) begin
          errors++; $display("FAIL band_last blk%0d: got %b expected 0", k, s_last);
        end
        k++;
      end
    end
    checks++;
    if (k !== 32) begin
      errors++; $display("FAIL band_count: got %0d expected 32", k);
    end
    checks++;
    if (first_val !== acc_edge + 1) begin
      errors++;
      $display("FAIL band_latency: first valid at cycle %0d expected %0d", first_val, acc_edge + 1);
    end
    checks++;
    if (rdy_ok !== 1'b1) begin
      errors++; $display("FAIL band_pix_ready: got deassert expected always 1");
    end
    checks++;
    if (blk_valid !== 1'b0) begin
      errors++; $display("FAIL band_idle_valid: got %b expected 0", blk_valid);
    end
    $display("test_one_band: %0d blocks, first valid cycle %0d", k, first_val);
  endtask

  // Whole frame back-to-back: 1024 blocks in band/column order.
  task automatic test_full_frame();
    int w = 0, k = 0, lasts = 0;
    bit rdy_ok = 1'b1;
    logic [63:0] exp_row;
    do_reset();
    for (int n = 0; n < 9000 && k < 1024; n++) begin
      step(w < 8192, pix(16'hC35A, w / 32, w % 32), 1'b1);
      if (!s_prdy) rdy_ok = 1'b0;
      if (p_acc) w++;
      if (b_acc) begin
        for (int r = 0; r < 8; r++) begin
          exp_row = pix(16'hC35A, (k / 32) * 8 + r, k % 32);
          checks++;
          if (s_rows[r] !== exp_row) begin
            errors++;
            $display("FAIL frame_row blk%0d row%0d: got %h expected %h", k, r, s_rows[r], exp_row);
          end
        end
        checks++;
        if (s_last !== (k == 1023)) begin
          errors++;
          $display("FAIL frame_last blk%0d: got %b expected %b", k, s_last, (k == 1023));
        end
        if (s_last) lasts++;
        k++;
      end
    end
    checks++;
    if (k !== 1024) begin
      errors++; $display("FAIL frame_count: got %0d expected 1024", k);
    end
    checks++;
    if (lasts !== 1) begin
      errors++; $display("FAIL frame_last_count: got %0d expected 1", lasts);
    end
    checks++;
    if (rdy_ok !== 1'b1) begin
      errors++; $display("FAIL frame_pix_ready: got deassert expected always 1");
    end
    $display("test_full_frame: %0d blocks, %0d words", k, w);
  endtask

  // Consumer stalled from the start: both banks fill, writer stalls, block 0
  // holds; on release 64 blocks stream with no gaps.
  task automatic test_backpressure();
    int w = 0, k = 0, drop_at = -1, prev = -1, gaps = 0;
    logic [63:0] exp_row;
    do_reset();
    for (int n = 0; n < 600 && drop_at < 0; n++) begin
      step(1'b1, pix(16'h3C3C, w / 32, w % 32), 1'b0);
      if (!s_prdy) drop_at = w;
      if (p_acc) w++;
    end
    checks++;
    if (drop_at !== 512) begin
      errors++; $display("FAIL bp_drop_point: got %0d expected 512", drop_at);
    end
    for (int n = 0; n < 6; n++) begin
      step(1'b1, pix(16'h3C3C, 16, 0), 1'b0);
      checks++;
      if (s_prdy !== 1'b0 || s_bval !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_flags: got ready=%b valid=%b expected ready=0 valid=1", s_prdy, s_bval);
      end
      for (int r = 0; r < 8; r++) begin
        exp_row = pix(16'h3C3C, r, 0);
        checks++;
        if (s_rows[r] !== exp_row) begin
          errors++;
          $display("FAIL bp_hold_row%0d: got %h expected %h", r, s_rows[r], exp_row);
        end
      end
    end
    for (int n = 0; n < 200 && k < 64; n++) begin
      step(1'b0, '0, 1'b1);
      if (b_acc) begin
        if (prev >= 0 && cyc != prev + 1) gaps++;
        prev = cyc;
        for (int r = 0; r < 8; r++) begin
          exp_row = pix(16'h3C3C, (k / 32) * 8 + r, k % 32);
          checks++;
          if (s_rows[r] !== exp_row) begin
            errors++;
            $display("FAIL bp_row blk%0d row%0d: got %h expected %h", k, r, s_rows[r], exp_row);
          end
        end
        k++;
      end
    end
    checks++;
    if (k !== 64) begin
      errors++; $display("FAIL bp_count: got %0d expected 64", k);
    end
    checks++;
    if (gaps !== 0) begin
      errors++; $display("FAIL bp_gaps: got %0d expected 0", gaps);
    end
    $display("test_backpressure: stall after %0d words, %0d blocks", drop_at, k);
  endtask

  // Reset mid-band discards partial data; the fresh band starts at word 0.
  task automatic test_reset_partial();
    int w = 0, k = 0;
    bit stray = 1'b0;
    logic [63:0] exp_row;
    do_reset();
    for (int n = 0; n < 100; n++) begin
      step(1'b1, pix(16'h1111, n / 32, n % 32), 1'b1);
      if (s_bval) stray = 1'b1;
    end
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(w < 256, pix(16'h2222, w / 32, w % 32), 1'b1);
      if (p_acc) w++;
      if (b_acc) begin
        for (int r = 0; r < 8; r++) begin
          exp_row = pix(16'h2222, r, k);
          checks++;
          if (s_rows[r] !== exp_row) begin
            errors++;
            $display("FAIL rp_row blk%0d row%0d: got %h expected %h", k, r, s_rows[r], exp_row);
          end
        end
        k++;
      end
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++; $display("FAIL rp_partial_block: got valid expected none");
    end
    checks++;
    if (k !== 32) begin
      errors++; $display("FAIL rp_count: got %0d expected 32", k);
    end
    $display("test_reset_partial: %0d blocks from fresh band", k);
  endtask

  // Bank 0's last block loads at the same edge bank 1's last word lands.
  task automatic test_bank_handoff();
    int w = 0, k = 0;
    bit chk_next = 1'b0, handoff_seen = 1'b0;
    logic [63:0] exp_row;
    do_reset();
    for (int n = 0; n < 700; n++) begin
      step(w <= 512, pix(16'h6969, w / 32, w % 32), w >= 481);
      if (chk_next) begin
        chk_next     = 1'b0;
        handoff_seen = 1'b1;
        checks++;
        if (s_prdy !== 1'b1 || s_bval !== 1'b1 || k !== 31) begin
          errors++;
          $display("FAIL handoff_state: got ready=%b valid=%b blocks=%0d expected ready=1 valid=1 blocks=31",
                   s_prdy, s_bval, k);
        end
      end
      if (p_acc && w == 511) chk_next = 1'b1;
      if (p_acc) w++;
      if (b_acc) begin
        for (int r = 0; r < 8; r++) begin
          exp_row = pix(16'h6969, (k / 32) * 8 + r, k % 32);
          checks++;
          if (s_rows[r] !== exp_row) begin
            errors++;
            $display("FAIL handoff_row blk%0d row%0d: got %h expected %h", k, r, s_rows[r], exp_row);
          end
        end
        k++;
      end
    end
    checks++;
    if (handoff_seen !== 1'b1 || w !== 513) begin
      errors++;
      $display("FAIL handoff_words: got %0d words seen=%b expected 513 seen=1", w, handoff_seen);
    end
    checks++;
    if (k !== 64) begin
      errors++; $display("FAIL handoff_count: got %0d expected 64", k);
    end
    $display("test_bank_handoff: %0d words, %0d blocks", w, k);
  endtask

  initial begin
    test_reset();
    test_one_band();
    test_full_frame();
    test_reset();
    test_backpressure();
    test_reset_partial();
    test_bank_handoff();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
